// File: rtl/loop_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : loop_down_counter
// Brief    : Loadable trip-count down-counter with start/abort/done control,
//            optional auto-reload and a reload tally.
// Revision : 1.0  initial release
// ============================================================================
module loop_down_counter #(
  parameter int WIDTH_COUNT  = 64,
  parameter int WIDTH_RELOAD = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Load,
  input  logic [WIDTH_COUNT-1:0]  I_LoadVal,
  input  logic                    I_Start,
  input  logic                    I_En,
  input  logic                    I_Abort,
  input  logic                    I_AutoReload,
  output logic [WIDTH_COUNT-1:0]  O_CountVal,
  output logic                    O_Busy,
  output logic                    O_Last,
  output logic                    O_Done,
  output logic [WIDTH_RELOAD-1:0] O_ReloadCnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH_COUNT-1:0]  c_count_one  = WIDTH_COUNT'(1);
  localparam logic [WIDTH_RELOAD-1:0] c_reload_one = WIDTH_RELOAD'(1);

  state_t                  r_state,      w_state_nxt;
  logic [WIDTH_COUNT-1:0]  r_count,      w_count_nxt;
  logic [WIDTH_COUNT-1:0]  r_reload,     w_reload_nxt;
  logic [WIDTH_RELOAD-1:0] r_reload_cnt, w_reload_cnt_nxt;
  logic                    r_done,       w_done_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_reload     <= '0;
      r_reload_cnt <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_reload     <= w_reload_nxt;
      r_reload_cnt <= w_reload_cnt_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_reload_nxt     = r_reload;
    w_reload_cnt_nxt = r_reload_cnt;
    w_done_nxt       = 1'b0;

    if (I_Load) begin
      w_count_nxt      = I_LoadVal;
      w_reload_nxt     = I_LoadVal;
      w_reload_cnt_nxt = '0;
      w_state_nxt      = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (I_Start) begin
            // A zero trip count completes without ever entering RUN.
            if (r_count != '0) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (I_Abort) begin
            w_state_nxt = ST_IDLE;
          end else if (I_En) begin
            if (r_count == c_count_one) begin
              w_done_nxt = 1'b1;
              if (I_AutoReload) begin
                w_count_nxt      = r_reload;
                w_reload_cnt_nxt = r_reload_cnt + c_reload_one;
              end else begin
                w_count_nxt = '0;
                w_state_nxt = ST_DONE;
              end
            end else if (r_count != '0) begin
              w_count_nxt = r_count - c_count_one;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign O_CountVal  = r_count;
  assign O_Busy      = (r_state == ST_RUN);
  assign O_Last      = (r_state == ST_RUN) && (r_count == c_count_one);
  assign O_Done      = r_done;
  assign O_ReloadCnt = r_reload_cnt;

endmodule
`default_nettype wire

// File: tb/tb_loop_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_down_counter
// Brief    : Directed vector table plus randomized run against a trip-count model.
// Revision : 1.0  initial release
// ============================================================================
module tb_loop_down_counter;

  localparam int WC = 64;
  localparam int WR = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          I_Load, I_Start, I_En, I_Abort, I_AutoReload;
  logic [WC-1:0] I_LoadVal;
  logic [WC-1:0] O_CountVal;
  logic          O_Busy, O_Last, O_Done;
  logic [WR-1:0] O_ReloadCnt;

  int errors = 0;
  int checks = 0;

  loop_down_counter #(.WIDTH_COUNT(WC), .WIDTH_RELOAD(WR)) dut (
    .clock       (clock),
    .reset       (reset),
    .I_Load      (I_Load),
    .I_LoadVal   (I_LoadVal),
    .I_Start     (I_Start),
    .I_En        (I_En),
    .I_Abort     (I_Abort),
    .I_AutoReload(I_AutoReload),
    .O_CountVal  (O_CountVal),
    .O_Busy      (O_Busy),
    .O_Last      (O_Last),
    .O_Done      (O_Done),
    .O_ReloadCnt (O_ReloadCnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst, ld, st, en, ab, ar;
    logic [WC-1:0] val;
    logic [WC-1:0] e_cnt;
    logic          e_busy, e_last, e_done;
    logic [WR-1:0] e_rc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ld, logic [WC-1:0] val, logic st, logic en,
                              logic ab, logic ar, logic [WC-1:0] e_cnt, logic e_busy,
                              logic e_last, logic e_done, logic [WR-1:0] e_rc);
    vec_t v;
    v.rst = rst; v.ld = ld; v.val = val; v.st = st; v.en = en; v.ab = ab; v.ar = ar;
    v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_last = e_last; v.e_done = e_done; v.e_rc = e_rc;
    return v;
  endfunction

  task automatic check(input string name, input logic [WC-1:0] act, input logic [WC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs shortly after an edge, then sample after the next edge.
  task automatic apply(input logic rst, input logic ld, input logic [WC-1:0] val, input logic st,
                       input logic en, input logic ab, input logic ar);
    reset = rst; I_Load = ld; I_LoadVal = val; I_Start = st;
    I_En = en; I_Abort = ab; I_AutoReload = ar;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [WC-1:0] cnt, input logic busy,
                           input logic last, input logic done, input logic [WR-1:0] rc);
    check({tag, " count"}, O_CountVal, cnt);
    check({tag, " busy"},  {63'd0, O_Busy}, {63'd0, busy});
    check({tag, " last"},  {63'd0, O_Last}, {63'd0, last});
    check({tag, " done"},  {63'd0, O_Done}, {63'd0, done});
    check({tag, " rcnt"},  {61'd0, O_ReloadCnt}, {61'd0, rc});
  endtask

  // Reference model: remaining trips, reload value, reload tally and a phase name.
  int unsigned   m_phase;  // 0 idle, 1 running, 2 finishing
  logic [WC-1:0] m_remaining, m_trip;
  int unsigned   m_reloads;
  logic          m_done;

  task automatic model_step(input logic rst, input logic ld, input logic [WC-1:0] val,
                            input logic st, input logic en, input logic ab, input logic ar);
    m_done = 1'b0;
    if (rst) begin
      m_phase = 0; m_remaining = '0; m_trip = '0; m_reloads = 0;
    end else if (ld) begin
      m_phase = 0; m_remaining = val; m_trip = val; m_reloads = 0;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (st) begin
        m_phase = (m_remaining == 0) ? 2 : 1;
        m_done  = (m_remaining == 0);
      end
    end else if (ab) begin
      m_phase = 0;
    end else if (en && m_remaining > 0) begin
      m_remaining = m_remaining - 1;
      if (m_remaining == 0) begin
        m_done = 1'b1;
        if (ar) begin
          m_remaining = m_trip;
          m_reloads   = (m_reloads + 1) % (1 << WR);
        end else begin
          m_phase = 2;
        end
      end
    end
  endtask

  initial begin
    logic [WC-1:0] ones;
    ones = '1;

    // Reset, load 3, count down to done.
    vecs.push_back(mk(1,0,0, 0,0,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,1,3, 0,0,0,0,  3,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,0,  3,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  2,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  1,1,1,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  0,0,0,0,0));
    // Zero-trip start; start during the done cycle is dropped.
    vecs.push_back(mk(0,1,0, 0,0,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,0,0, 1,0,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0,  0,0,0,0,0));
    // Auto-reload of 2 over six steps, then abort.
    vecs.push_back(mk(0,1,2, 0,0,0,1,  2,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,1,  2,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,1,  1,1,1,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,1,  2,1,0,1,1));
    vecs.push_back(mk(0,0,0, 0,1,0,1,  1,1,1,0,1));
    vecs.push_back(mk(0,0,0, 0,1,0,1,  2,1,0,1,2));
    vecs.push_back(mk(0,0,0, 0,1,0,1,  1,1,1,0,2));
    vecs.push_back(mk(0,0,0, 0,1,0,1,  2,1,0,1,3));
    vecs.push_back(mk(0,0,0, 0,0,1,1,  2,0,0,0,3));
    // Abort with step, restart, finish.
    vecs.push_back(mk(0,1,5, 0,0,0,0,  5,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,0,  5,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  4,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  3,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,1,0,  3,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,0,  3,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  2,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  1,1,1,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  0,0,0,1,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0,  0,0,0,0,0));
    // Reload value 1: back-to-back done pulses and tally wrap.
    vecs.push_back(mk(0,1,1, 0,0,0,1,  1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,1,  1,1,1,0,0));
    for (int k = 0; k < 9; k++)
      vecs.push_back(mk(0,0,0, 0,1,0,1,  1,1,1,1,WR'((k + 1) % 8)));
    // Load wins over step/abort/start mid-run.
    vecs.push_back(mk(0,1,9, 1,1,1,1,  9,0,0,0,0));
    vecs.push_back(mk(0,1,5, 0,0,0,0,  5,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,0,  5,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  4,1,0,0,0));
    vecs.push_back(mk(0,1,9, 1,1,1,0,  9,0,0,0,0));
    // Reset at last step.
    vecs.push_back(mk(0,1,4, 0,0,0,0,  4,0,0,0,0));
    vecs.push_back(mk(0,0,0, 1,0,0,0,  4,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  3,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  2,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  1,1,1,0,0));
    vecs.push_back(mk(1,0,0, 0,1,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,1,0,0,  0,0,0,0,0));
    // Full-width load decrements without wrap.
    vecs.push_back(mk(0,1,ones, 0,0,0,0, ones,0,0,0,0));
    vecs.push_back(mk(0,0,0,    1,0,0,0, ones,1,0,0,0));
    vecs.push_back(mk(0,0,0,    0,1,0,0, ones - 1,1,0,0,0));

    reset = 1'b1; I_Load = 0; I_LoadVal = '0; I_Start = 0;
    I_En = 0; I_Abort = 0; I_AutoReload = 0;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].ld, vecs[i].val, vecs[i].st, vecs[i].en, vecs[i].ab, vecs[i].ar);
      check_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_last,
                vecs[i].e_done, vecs[i].e_rc);
    end

    for (int n = 0; n < 3000; n++) begin
      logic          rst, ld, st, en, ab, ar;
      logic [WC-1:0] val;
      rst = (n == 0) || ($urandom_range(0, 149) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      val = WC'($urandom_range(0, 4));
      st  = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 1) == 1);
      ab  = ($urandom_range(0, 24) == 0);
      ar  = ($urandom_range(0, 3) != 0);
      apply(rst, ld, val, st, en, ab, ar);
      model_step(rst, ld, val, st, en, ab, ar);
      check_all($sformatf("rnd%0d", n), m_remaining, (m_phase == 1),
                (m_phase == 1) && (m_remaining == 1), m_done, WR'(m_reloads));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
